// File: rtl/mux_n_rr_if.sv
// Stream bundle for mux_n_rr: N producer lanes in, one consumer stream out.
interface mux_n_rr_if #(
    parameter int unsigned N     = 4,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SELW  = $clog2(N)
);
    logic                 mode;
    logic [SELW-1:0]      sel;
    logic [N*WIDTH-1:0]   in_data;
    logic [N-1:0]         in_valid;
    logic [N-1:0]         in_ready;
    logic [WIDTH-1:0]     out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [SELW-1:0]      out_ch;

    // Environment side: drives producers' data/valid and the consumer's ready
    modport master (
        output mode, sel, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_ch
    );

    // Mux side
    modport slave (
        input  mode, sel, in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_ch
    );
endinterface

// File: rtl/mux_n_rr.sv
// N-channel stream mux with registered output, fixed or round-robin selection.
module mux_n_rr #(
    parameter int unsigned N     = 4,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SELW  = $clog2(N)
) (
    input  logic      clk,
    input  logic      rst_n,
    mux_n_rr_if.slave bus
);
    logic [WIDTH-1:0] lane [N];

    logic [SELW-1:0]  ptr_q, ptr_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [SELW-1:0]  out_ch_q, out_ch_d;

    logic             load_en_c;
    logic             hit_c;
    logic             gnt_c;
    logic [SELW-1:0]  cand_c;
    logic             rr_hit_c;
    logic [SELW-1:0]  rr_cand_c;
    logic [N-1:0]     in_ready_c;

    // Unpack the flat data bus into per-channel lanes
    for (genvar g = 0; g < N; g++) begin : g_lane
        assign lane[g] = bus.in_data[g*WIDTH +: WIDTH];
    end

    // Round-robin scan: first valid channel starting at ptr, wrapping modulo N
    always_comb begin
        rr_hit_c  = 1'b0;
        rr_cand_c = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (!rr_hit_c && bus.in_valid[SELW'((32'(ptr_q) + k) % N)]) begin
                rr_hit_c  = 1'b1;
                rr_cand_c = SELW'((32'(ptr_q) + k) % N);
            end
        end
    end

    // Candidate choice and grant; ready is suppressed while in reset
    always_comb begin
        load_en_c = !out_valid_q || bus.out_ready;
        if (bus.mode) begin
            cand_c = rr_cand_c;
            hit_c  = rr_hit_c;
        end else begin
            cand_c = bus.sel;
            hit_c  = (32'(bus.sel) < N) && bus.in_valid[bus.sel];
        end
        gnt_c = rst_n && load_en_c && hit_c;
        for (int unsigned i = 0; i < N; i++) begin
            in_ready_c[i] = gnt_c && (cand_c == SELW'(i));
        end
    end

    // Next-state for the output register and round-robin pointer
    always_comb begin
        ptr_d       = ptr_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_ch_d    = out_ch_q;
        if (gnt_c) begin
            out_data_d  = lane[cand_c];
            out_ch_d    = cand_c;
            out_valid_d = 1'b1;
            if (bus.mode) begin
                ptr_d = (cand_c == SELW'(N - 1)) ? '0 : cand_c + SELW'(1);
            end
        end else if (load_en_c) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
        end else begin
            ptr_q       <= ptr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_ch    = out_ch_q;
endmodule
